lane_sum_receiver: RTL and testbench
====================================

# lane_sum_receiver

Receiving end of the 8-lane streaming interface driven by the data-feeding shift register: one 8-lane vector per cycle, qualified by `in_valid`. Sums each vector through a pipelined 8→4→2→1 adder tree and accumulates the vector sums over a burst of `BEATS` valid vectors. Reports each vector sum, the running burst total and a one-cycle completion pulse. Sits between the feeder and the LED/display logic, which taps `total`.

## Interface
- `DATA_W`, 8, width of each input lane
- `BEATS`, 32, valid vectors per burst
- `SUM_W`, 32, width of `sum` and `total`
- `clk`  in  1  single clock; all state on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  qualifies `in0..in7` in the current cycle
- `in0`..`in7`  in  DATA_W each  unsigned lane data
- `beat_sum`  out  DATA_W+3  sum of one accepted vector
- `beat_valid`  out  1  `beat_sum` valid this cycle
- `sum`  out  SUM_W  running total of the current burst
- `beat_cnt`  out  $clog2(BEATS+1)  valid vectors accumulated in the current burst
- `total`  out  SUM_W  final total of the last completed burst, held
- `done`  out  1  one-cycle pulse when a burst completes

## Operation
- Reset (async assert, any cycle): pipeline valids, `beat_sum`, `beat_valid`, `sum`, `beat_cnt`, `total` and `done` all 0. In-flight vectors are discarded, not replayed.
- Lanes are unsigned. Stage 1 adds pairs (0+1, 2+3, 4+5, 6+7) to DATA_W+1 bits. Stage 2 adds to DATA_W+2 bits. Stage 3 adds to DATA_W+3 bits, so overflow is impossible.
- Each stage carries a valid bit. Data registers load only when the incoming valid is 1 and hold otherwise. Lane values are ignored while `in_valid` = 0.
- Accumulator FSM has two states:
  - IDLE (`beat_cnt` = 0): on `beat_valid`, `sum` ← zero-extended `beat_sum`, `beat_cnt` ← 1, go to ACCUM.
  - ACCUM: on `beat_valid`, `sum` ← `sum` + `beat_sum` (modulo 2^SUM_W) and `beat_cnt` increments.
  - When the accepted beat is number `BEATS`: `total` ← final value, `done` ← 1, `sum` ← 0, `beat_cnt` ← 0, go to IDLE.
  - Cycles without `beat_valid` change nothing.
- `done` is 0 in every cycle except the one after a burst completes.
- Back-to-back bursts need no gap. The beat after the completing beat starts the next burst.
- If `BEATS` = 1, every valid vector completes a burst.

## Timing
- A vector presented with `in_valid` in cycle t produces `beat_valid`/`beat_sum` in cycle t+3.
- The same vector updates `sum`/`beat_cnt` in cycle t+4. For the completing beat, `done`/`total` update in cycle t+4.
- Throughput is one vector per cycle, with no backpressure. Bubbles propagate unchanged through the pipeline.
- Reset released in cycle r: a vector presented in cycle r+1 is accepted.

## Structure
- Shared package holds `DATA_W`, `BEATS` and `SUM_W` defaults, plus a derived constant `BEAT_W` = DATA_W+3.
- One sub-module, `pair_add_stage`: parameterised width W and count N. It holds N registered pairwise adders plus a valid flop, and is instantiated three times (N = 4, 2, 1).
- The accumulator FSM, counter and output registers live in the top level.

## Test plan
- All lanes 0xFF, `in_valid` high for 32 cycles → `beat_sum` = 2040 each beat; `done` 35 cycles after the first vector; `total` = 65280 (0xFF00).
- Vector k (k = 0..31) has every lane = k → `beat_sum` = 8k; `total` = 3968; `sum` returns to 0 with `done`.
- Same 0x01 burst with `in_valid` low on alternating cycles, and lanes = 0xAA during the low cycles → `total` = 256, `done` after 32 valid beats only.
- Assert `rst` asynchronously mid-clock after 10 beats, release, then send 32 vectors of 0x02 → `done` only after the new 32 beats; `total` = 512; no `done` from the aborted burst.
- Two back-to-back bursts (lanes 0x01, then 0x03, 64 consecutive valid cycles) → two `done` pulses exactly 32 cycles apart; `total` = 256, then 768.
- `BEATS` = 1 build, three consecutive vectors → `done` high in three consecutive cycles; `total` tracks each `beat_sum`.

Source files
------------

// File: rtl/lane_sum_receiver_pkg.sv
// Shared defaults, derived widths and accumulator state type for the lane-sum receiver.
package lane_sum_receiver_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_BEATS  = 32;
  localparam int DEFAULT_SUM_W  = 32;
  localparam int BEAT_W         = DEFAULT_DATA_W + 3;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_t;

  // Eight unsigned lanes summed through three binary levels grow by three bits.
  function automatic int beat_width(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/lane_sum_receiver_pair_add_stage.sv
// One registered level of the adder tree: N pairwise adders of W-bit operands plus a valid flop.
module pair_add_stage #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [2*N-1:0][W-1:0]   operands,
  output logic                    valid,
  output logic [N-1:0][W:0]       sums
);

  // Sums hold their last value through bubbles; only the valid bit follows every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      sums  <= '0;
    end else begin
      valid <= load;
      if (load) begin
        for (int i = 0; i < N; i++) begin
          sums[i] <= {1'b0, operands[2*i]} + {1'b0, operands[2*i+1]};
        end
      end
    end
  end

endmodule

// File: rtl/lane_sum_receiver.sv
// Sums each 8-lane vector through a 3-stage adder tree and accumulates bursts of BEATS vector sums.
module lane_sum_receiver
  import lane_sum_receiver_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BEATS  = DEFAULT_BEATS,
  parameter int SUM_W  = DEFAULT_SUM_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in0,
  input  logic [DATA_W-1:0]            in1,
  input  logic [DATA_W-1:0]            in2,
  input  logic [DATA_W-1:0]            in3,
  input  logic [DATA_W-1:0]            in4,
  input  logic [DATA_W-1:0]            in5,
  input  logic [DATA_W-1:0]            in6,
  input  logic [DATA_W-1:0]            in7,
  output logic [DATA_W+2:0]            beat_sum,
  output logic                         beat_valid,
  output logic [SUM_W-1:0]             sum,
  output logic [$clog2(BEATS+1)-1:0]   beat_cnt,
  output logic [SUM_W-1:0]             total,
  output logic                         done
);

  localparam int BW    = beat_width(DATA_W);
  localparam int CNT_W = $clog2(BEATS + 1);

  logic [7:0][DATA_W-1:0] lanes;
  logic                   s1_valid;
  logic                   s2_valid;
  logic [3:0][DATA_W:0]   s1_sums;
  logic [1:0][DATA_W+1:0] s2_sums;
  logic [0:0][BW-1:0]     s3_sums;

  assign lanes    = {in7, in6, in5, in4, in3, in2, in1, in0};
  assign beat_sum = s3_sums[0];

  pair_add_stage #(.W(DATA_W),     .N(4)) u_stage1 (
    .clk(clk), .rst(rst), .load(in_valid), .operands(lanes),
    .valid(s1_valid), .sums(s1_sums)
  );

  pair_add_stage #(.W(DATA_W + 1), .N(2)) u_stage2 (
    .clk(clk), .rst(rst), .load(s1_valid), .operands(s1_sums),
    .valid(s2_valid), .sums(s2_sums)
  );

  pair_add_stage #(.W(DATA_W + 2), .N(1)) u_stage3 (
    .clk(clk), .rst(rst), .load(s2_valid), .operands(s2_sums),
    .valid(beat_valid), .sums(s3_sums)
  );

  acc_state_t       state;
  acc_state_t       state_next;
  logic [SUM_W-1:0] sum_next;
  logic [SUM_W-1:0] total_next;
  logic [SUM_W-1:0] beat_total;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACC_IDLE;
      sum      <= '0;
      beat_cnt <= '0;
      total    <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      sum      <= sum_next;
      beat_cnt <= cnt_next;
      total    <= total_next;
      done     <= done_next;
    end
  end

  // The completing beat latches the total and clears the running sum so the next beat starts fresh.
  always_comb begin
    state_next = state;
    sum_next   = sum;
    cnt_next   = beat_cnt;
    total_next = total;
    done_next  = 1'b0;
    beat_total = '0;
    cnt_inc    = '0;
    if (beat_valid) begin
      case (state)
        ACC_IDLE: begin
          beat_total = SUM_W'(beat_sum);
          cnt_inc    = CNT_W'(1);
        end
        ACC_ACCUM: begin
          beat_total = sum + SUM_W'(beat_sum);
          cnt_inc    = beat_cnt + 1'b1;
        end
        default: begin
          beat_total = '0;
          cnt_inc    = '0;
        end
      endcase
      if (cnt_inc == CNT_W'(BEATS)) begin
        total_next = beat_total;
        done_next  = 1'b1;
        sum_next   = '0;
        cnt_next   = '0;
        state_next = ACC_IDLE;
      end else begin
        sum_next   = beat_total;
        cnt_next   = cnt_inc;
        state_next = ACC_ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_lane_sum_receiver.sv
// Self-checking bench: a BEATS=32 and a BEATS=1 receiver share one stimulus stream and a cycle-level model.
module tb_lane_sum_receiver;

  localparam int DATA_W = 8;
  localparam int BEATS  = 32;
  localparam int SUM_W  = 32;
  localparam int MAXC   = 128;

  typedef struct packed {
    logic        bv;
    logic [10:0] bs;
    logic        done;
    logic [5:0]  cnt;
    logic [31:0] sum;
    logic [31:0] total;
  } snap_t;

  typedef struct packed {
    logic        done;
    logic [31:0] total;
    logic [31:0] sum;
    logic [0:0]  cnt;
    logic        bv;
    logic [10:0] bs;
  } snap1_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] lane [8];

  logic [10:0] beat_sum,  beat_sum1;
  logic        beat_valid, beat_valid1;
  logic [31:0] sum, sum1, total, total1;
  logic [5:0]  beat_cnt;
  logic [0:0]  beat_cnt1;
  logic        done, done1;

  int errors = 0;
  int checks = 0;

  logic        st_valid [MAXC];
  logic [7:0]  st_lane  [MAXC][8];
  snap_t       obs  [MAXC];
  snap_t       ex   [MAXC];
  snap1_t      obs1 [MAXC];
  snap1_t      ex1  [MAXC];

  // Model state that survives between runs (cleared only by reset).
  int unsigned m_run = 0, m_cnt = 0, m_total = 0, m1_total = 0;
  logic [10:0] m_bs = '0;

  lane_sum_receiver #(.DATA_W(DATA_W), .BEATS(BEATS), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in0(lane[0]), .in1(lane[1]), .in2(lane[2]), .in3(lane[3]),
    .in4(lane[4]), .in5(lane[5]), .in6(lane[6]), .in7(lane[7]),
    .beat_sum(beat_sum), .beat_valid(beat_valid), .sum(sum),
    .beat_cnt(beat_cnt), .total(total), .done(done)
  );

  lane_sum_receiver #(.DATA_W(DATA_W), .BEATS(1), .SUM_W(SUM_W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in0(lane[0]), .in1(lane[1]), .in2(lane[2]), .in3(lane[3]),
    .in4(lane[4]), .in5(lane[5]), .in6(lane[6]), .in7(lane[7]),
    .beat_sum(beat_sum1), .beat_valid(beat_valid1), .sum(sum1),
    .beat_cnt(beat_cnt1), .total(total1), .done(done1)
  );

  always #5 clk = ~clk;

  function automatic int unsigned lanesum(input int c);
    int unsigned s = 0;
    for (int l = 0; l < 8; l++) s += st_lane[c][l];
    return s;
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      st_valid[c] = 1'b0;
      for (int l = 0; l < 8; l++) st_lane[c][l] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      obs[c].bv    = beat_valid;
      obs[c].bs    = beat_sum;
      obs[c].done  = done;
      obs[c].cnt   = beat_cnt;
      obs[c].sum   = sum;
      obs[c].total = total;
      obs1[c].done  = done1;
      obs1[c].total = total1;
      obs1[c].sum   = sum1;
      obs1[c].cnt   = beat_cnt1;
      obs1[c].bv    = beat_valid1;
      obs1[c].bs    = beat_sum1;
      in_valid = st_valid[c];
      for (int l = 0; l < 8; l++) lane[l] = st_lane[c][l];
    end
  endtask

  // A vector driven in cycle c appears as a beat at c+3 and lands in the accumulator at c+4.
  task automatic build_expect(input int n);
    for (int c = 0; c < n; c++) begin
      logic bv = 1'b0;
      logic dn = 1'b0;
      logic dn1 = 1'b0;
      if (c >= 3 && st_valid[c-3]) begin
        bv   = 1'b1;
        m_bs = 11'(lanesum(c-3));
      end
      if (c >= 4 && st_valid[c-4]) begin
        int unsigned s = lanesum(c-4);
        m_run += s;
        m_cnt++;
        if (m_cnt == BEATS) begin
          m_total = m_run;
          m_run = 0;
          m_cnt = 0;
          dn = 1'b1;
        end
        m1_total = s;
        dn1 = 1'b1;
      end
      ex[c]  = '{bv: bv, bs: m_bs, done: dn, cnt: 6'(m_cnt), sum: m_run, total: m_total};
      ex1[c] = '{done: dn1, total: m1_total, sum: 32'd0, cnt: 1'b0, bv: bv, bs: m_bs};
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    for (int l = 0; l < 8; l++) lane[l] = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({beat_valid, beat_sum, done, beat_cnt, sum, total} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got bv=%b bs=%0d done=%b cnt=%0d sum=%0d total=%0d, expected all 0",
               beat_valid, beat_sum, done, beat_cnt, sum, total);
    end
    checks++;
    if ({beat_valid1, done1, total1} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state_b1: got bv=%b done=%b total=%0d, expected all 0", beat_valid1, done1, total1);
    end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_all_ff();
    int n_done = 0;
    clear_stim();
    for (int c = 0; c < 32; c++) begin
      st_valid[c] = 1'b1;
      for (int l = 0; l < 8; l++) st_lane[c][l] = 8'hFF;
    end
    run(40);
    build_expect(40);
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (obs[c] !== ex[c]) begin
        errors++;
        $display("[TB] FAIL all_ff cycle %0d: got %h expected %h", c, obs[c], ex[c]);
      end
      if (obs[c].done) n_done++;
    end
    checks++;
    if (obs[3].bs !== 11'd2040) begin
      errors++;
      $display("[TB] FAIL all_ff_beat_sum: got %0d expected 2040", obs[3].bs);
    end
    checks++;
    if (obs[35].done !== 1'b1 || obs[35].total !== 32'd65280 || n_done != 1) begin
      errors++;
      $display("[TB] FAIL all_ff_total: got done@35=%b total=%0d pulses=%0d expected 1 65280 1",
               obs[35].done, obs[35].total, n_done);
    end
  endtask

  task automatic test_ramp();
    clear_stim();
    for (int c = 0; c < 32; c++) begin
      st_valid[c] = 1'b1;
      for (int l = 0; l < 8; l++) st_lane[c][l] = 8'(c);
    end
    run(40);
    build_expect(40);
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (obs[c] !== ex[c]) begin
        errors++;
        $display("[TB] FAIL ramp cycle %0d: got %h expected %h", c, obs[c], ex[c]);
      end
    end
    checks++;
    if (obs[34].bs !== 11'd248 || obs[35].total !== 32'd3968 || obs[35].sum !== 32'd0 || obs[35].done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ramp_total: got bs=%0d total=%0d sum=%0d done=%b expected 248 3968 0 1",
               obs[34].bs, obs[35].total, obs[35].sum, obs[35].done);
    end
  endtask

  task automatic test_gaps();
    int n_done = 0;
    clear_stim();
    for (int c = 0; c < 64; c++) begin
      st_valid[c] = (c % 2 == 0);
      for (int l = 0; l < 8; l++) st_lane[c][l] = (c % 2 == 0) ? 8'h01 : 8'hAA;
    end
    run(72);
    build_expect(72);
    for (int c = 0; c < 72; c++) begin
      checks++;
      if (obs[c] !== ex[c]) begin
        errors++;
        $display("[TB] FAIL gaps cycle %0d: got %h expected %h", c, obs[c], ex[c]);
      end
      if (obs[c].done) n_done++;
    end
    checks++;
    if (obs[66].done !== 1'b1 || obs[66].total !== 32'd256 || n_done != 1) begin
      errors++;
      $display("[TB] FAIL gaps_total: got done@66=%b total=%0d pulses=%0d expected 1 256 1",
               obs[66].done, obs[66].total, n_done);
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    clear_stim();
    for (int c = 0; c < 64; c++) begin
      st_valid[c] = 1'b1;
      for (int l = 0; l < 8; l++) st_lane[c][l] = (c < 32) ? 8'h01 : 8'h03;
    end
    run(74);
    build_expect(74);
    for (int c = 0; c < 74; c++) begin
      checks++;
      if (obs[c] !== ex[c]) begin
        errors++;
        $display("[TB] FAIL b2b cycle %0d: got %h expected %h", c, obs[c], ex[c]);
      end
      if (obs[c].done) n_done++;
    end
    checks++;
    if (obs[35].done !== 1'b1 || obs[35].total !== 32'd256 || obs[67].done !== 1'b1
        || obs[67].total !== 32'd768 || n_done != 2) begin
      errors++;
      $display("[TB] FAIL b2b_totals: got done35=%b t=%0d done67=%b t=%0d pulses=%0d expected 1 256 1 768 2",
               obs[35].done, obs[35].total, obs[67].done, obs[67].total, n_done);
    end
  endtask

  task automatic test_async_reset();
    int n_done = 0;
    clear_stim();
    for (int c = 0; c < 10; c++) st_valid[c] = 1'b1;
    run(12);
    build_expect(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obs[c] !== ex[c]) begin
        errors++;
        $display("[TB] FAIL pre_reset cycle %0d: got %h expected %h", c, obs[c], ex[c]);
      end
    end
    checks++;
    if (obs[11].cnt !== 6'd8) begin
      errors++;
      $display("[TB] FAIL pre_reset_cnt: got %0d expected 8", obs[11].cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({beat_valid, done, beat_cnt, sum, total} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got bv=%b done=%b cnt=%0d sum=%0d total=%0d expected all 0",
               beat_valid, done, beat_cnt, sum, total);
    end
    m_run = 0; m_cnt = 0; m_total = 0; m1_total = 0; m_bs = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stim();
    for (int c = 0; c < 32; c++) begin
      st_valid[c] = 1'b1;
      for (int l = 0; l < 8; l++) st_lane[c][l] = 8'h02;
    end
    run(40);
    build_expect(40);
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (obs[c] !== ex[c]) begin
        errors++;
        $display("[TB] FAIL post_reset cycle %0d: got %h expected %h", c, obs[c], ex[c]);
      end
      if (obs[c].done) n_done++;
    end
    checks++;
    if (obs[35].done !== 1'b1 || obs[35].total !== 32'd512 || n_done != 1) begin
      errors++;
      $display("[TB] FAIL post_reset_total: got done@35=%b total=%0d pulses=%0d expected 1 512 1",
               obs[35].done, obs[35].total, n_done);
    end
  endtask

  task automatic test_beats_one();
    clear_stim();
    for (int c = 0; c < 3; c++) st_valid[c] = 1'b1;
    run(10);
    build_expect(10);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs1[c] !== ex1[c]) begin
        errors++;
        $display("[TB] FAIL beats_one cycle %0d: got %h expected %h", c, obs1[c], ex1[c]);
      end
      checks++;
      if (obs[c] !== ex[c]) begin
        errors++;
        $display("[TB] FAIL beats_one_main cycle %0d: got %h expected %h", c, obs[c], ex[c]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs1[4+k].done !== 1'b1 || obs1[4+k].total !== 32'(lanesum(k))) begin
        errors++;
        $display("[TB] FAIL beats_one_pulse %0d: got done=%b total=%0d expected 1 %0d",
                 k, obs1[4+k].done, obs1[4+k].total, lanesum(k));
      end
    end
  endtask

  task automatic test_random();
    clear_stim();
    for (int c = 0; c < 120; c++) st_valid[c] = ($urandom_range(0, 9) < 7);
    run(126);
    build_expect(126);
    for (int c = 0; c < 126; c++) begin
      checks++;
      if (obs[c] !== ex[c]) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", c, obs[c], ex[c]);
      end
      checks++;
      if (obs1[c] !== ex1[c]) begin
        errors++;
        $display("[TB] FAIL random_b1 cycle %0d: got %h expected %h", c, obs1[c], ex1[c]);
      end
    end
  endtask

  initial begin
    for (int l = 0; l < 8; l++) lane[l] = '0;
    test_reset();
    test_all_ff();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_async_reset();
    test_beats_one();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
